// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the master's FSM state type.
package ahb_pkg;

  // Transfer type. Only IDLE and NONSEQ are used by a single-transfer master.
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Slave response.
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Transfer size.
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Burst type: this master only ever issues single transfers.
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_e;

  // A request is legal when its size is byte/half/word and the address is
  // naturally aligned to that size.
  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [2:0] hs;
    hs = {1'b0, size};
    case (hs)
      HSIZE_BYTE: is_legal = 1'b1;
      HSIZE_HALF: is_legal = (addr_lo[0] == 1'b0);
      HSIZE_WORD: is_legal = (addr_lo == 2'b00);
      default:    is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_mst.sv
// Single-transfer, non-pipelined AHB-Lite master. A request is captured in
// IDLE, issued as one NONSEQ address phase, completed in the data phase, and
// reported one cycle later as an ack (OKAY) or err (ERROR) pulse. Illegal
// requests (size 11 or misaligned) are rejected without any bus activity.
module ahb_mst
  import ahb_pkg::*;
#(
  parameter int addr_w = 32
) (
  input  logic              hclk,
  input  logic              hreset,
  // request side
  input  logic              req,
  input  logic              we,
  input  logic [addr_w-1:0] addr,
  input  logic [31:0]       wd,
  input  logic [1:0]        size,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic [31:0]       rd,
  // AHB side
  output logic [addr_w-1:0] haddr,
  output logic [31:0]       hwdata,
  output logic              hwrite,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  input  logic [31:0]       hrdata,
  input  logic              hready,
  input  logic [1:0]        hresp
);

  state_e            state;
  state_e            state_nx;

  // Captured request.
  logic              we_q;
  logic [addr_w-1:0] addr_q;
  logic [31:0]       wd_q;
  logic [1:0]        size_q;

  // Completion status and read data.
  logic              resp_err_q;
  logic [31:0]       rd_q;

  // High for the single cycle following a rejected request.
  logic              rej_q;

  logic              sample;
  logic              accept;
  logic              reject;

  // A request is only looked at in IDLE and not during the reject cycle,
  // which counts as busy.
  assign sample = (state == ST_IDLE) && req && !rej_q;
  assign accept = sample &&  is_legal(size, addr[1:0]);
  assign reject = sample && !is_legal(size, addr[1:0]);

  // State register.
  always_ff @(posedge hclk or posedge hreset) begin
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of every other flop.
    if (hreset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and handshake/AHB control outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // this block leaves a signal unassigned (which would infer a latch).
    state_nx = state;
    htrans   = HTRANS_IDLE;
    busy     = 1'b1;
    ack      = 1'b0;
    err      = rej_q;
    case (state)
      ST_IDLE: begin
        busy = rej_q;
        if (accept) state_nx = ST_ADDR;
      end
      ST_ADDR: begin
        htrans = HTRANS_NONSEQ;
        if (hready) state_nx = ST_DATA;
      end
      ST_DATA: begin
        if (hready) state_nx = ST_DONE;
      end
      ST_DONE: begin
        ack      = !resp_err_q;
        err      =  resp_err_q;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Capture the request when it is accepted; held until the next accept.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
      size_q <= 2'b00;
    end else if (accept) begin
      we_q   <= we;
      addr_q <= addr;
      wd_q   <= wd;
      size_q <= size;
    end
  end

  // Sample the response (and read data on an OKAY read) at the end of the
  // data phase so they are visible in DONE alongside ack/err.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      resp_err_q <= 1'b0;
      rd_q       <= '0;
    end else if ((state == ST_DATA) && hready) begin
      resp_err_q <= (hresp != HRESP_OKAY);
      if (!we_q && (hresp == HRESP_OKAY)) rd_q <= hrdata;
    end
  end

  // Flag a rejected request for one cycle to produce the err pulse.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) rej_q <= 1'b0;
    else        rej_q <= reject;
  end

  // Bus signals come straight from the captured registers, so they are zero
  // in reset and stay quiet between transfers.
  assign haddr  = addr_q;
  assign hwrite = we_q;
  assign hwdata = wd_q;
  assign hsize  = {1'b0, size_q};
  assign hburst = HBURST_SINGLE;
  assign rd     = rd_q;

endmodule

// File: tb/tb_ahb_mst.sv
// Self-checking bench for ahb_mst: a table of hand-computed transfers, a
// randomized run against a transaction-level model, and hand-written
// sequences for request-while-busy and reset corner cases.
module tb_ahb_mst;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [1:0]  size;
  logic        busy;
  logic        ack;
  logic        err;
  logic [31:0] rd;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;

  int checks = 0;
  int errors = 0;
  int nonseq_cnt = 0;

  ahb_mst #(.addr_w(32)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wd     (wd),
    .size   (size),
    .busy   (busy),
    .ack    (ack),
    .err    (err),
    .rd     (rd),
    .haddr  (haddr),
    .hwdata (hwdata),
    .hwrite (hwrite),
    .htrans (htrans),
    .hsize  (hsize),
    .hburst (hburst),
    .hrdata (hrdata),
    .hready (hready),
    .hresp  (hresp)
  );

  always #5 hclk = ~hclk;

  // Count address phases seen on the bus.
  always @(negedge hclk) if (htrans == 2'b10) nonseq_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  size;
    int          aw;        // hready-low cycles in the address phase
    int          dw;        // hready-low cycles in the data phase
    logic        resp_err;  // slave answers with a two-cycle ERROR
    logic [31:0] rdata;
    logic        exp_legal;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_rd;
  } xfer_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic xfer_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] s, input int aw, input int dw,
                               input logic re, input logic [31:0] rdat, input logic el,
                               input logic ea, input logic ee, input logic [31:0] erd);
    xfer_t v;
    v.we = w; v.addr = a; v.wd = d; v.size = s; v.aw = aw; v.dw = dw;
    v.resp_err = re; v.rdata = rdat;
    v.exp_legal = el; v.exp_ack = ea; v.exp_err = ee; v.exp_rd = erd;
    return v;
  endfunction

  // Transaction-level reference: legality from natural alignment, outcome
  // from the slave response, rd only replaced by an OKAY read.
  function automatic xfer_t model(input xfer_t v, input logic [31:0] prev_rd);
    xfer_t r;
    int    nbytes;
    r = v;
    nbytes = 1 << v.size;
    r.exp_legal = (v.size != 2'd3) && ((v.addr % nbytes) == 0);
    r.exp_ack   = r.exp_legal && !v.resp_err;
    r.exp_err   = !r.exp_legal || v.resp_err;
    r.exp_rd    = (r.exp_ack && !v.we) ? v.rdata : prev_rd;
    return r;
  endfunction

  // Drive one request starting in the current (idle) cycle and check every
  // cycle of its life. Returns with the master idle again.
  task automatic run_xfer(input xfer_t v, input logic [31:0] prev_rd);
    req = 1'b1; we = v.we; addr = v.addr; wd = v.wd; size = v.size;
    hready = 1'b1; hresp = 2'b00; hrdata = $urandom;
    check("idle_busy", {31'b0, busy}, 32'd0);
    @(posedge hclk); #1;
    req = 1'b0; we = $urandom; addr = $urandom; wd = $urandom; size = $urandom;
    if (!v.exp_legal) begin
      check("rej_htrans", {30'b0, htrans}, 32'd0);
      check("rej_err", {31'b0, err}, 32'd1);
      check("rej_ack", {31'b0, ack}, 32'd0);
      check("rej_busy", {31'b0, busy}, 32'd1);
      @(posedge hclk); #1;
      check("rej_err_end", {31'b0, err}, 32'd0);
      check("rej_busy_end", {31'b0, busy}, 32'd0);
      check("rej_htrans_end", {30'b0, htrans}, 32'd0);
      return;
    end
    for (int i = 0; i <= v.aw; i++) begin
      hready = (i == v.aw);
      check("addr_htrans", {30'b0, htrans}, 32'h2);
      check("addr_haddr", haddr, v.addr);
      check("addr_hwrite", {31'b0, hwrite}, {31'b0, v.we});
      check("addr_hsize", {29'b0, hsize}, {30'b0, v.size});
      check("addr_hburst", {29'b0, hburst}, 32'd0);
      check("addr_done", {30'b0, ack, err}, 32'd0);
      check("addr_rd", rd, prev_rd);
      @(posedge hclk); #1;
    end
    for (int i = 0; i <= v.dw; i++) begin
      hready = (i == v.dw);
      hresp  = (v.resp_err && (i + 1 >= v.dw)) ? 2'b01 : 2'b00;
      hrdata = (i == v.dw) ? v.rdata : $urandom;
      check("data_htrans", {30'b0, htrans}, 32'd0);
      check("data_hwdata", hwdata, v.wd);
      check("data_haddr", haddr, v.addr);
      check("data_hwrite", {31'b0, hwrite}, {31'b0, v.we});
      check("data_busy", {31'b0, busy}, 32'd1);
      check("data_done", {30'b0, ack, err}, 32'd0);
      check("data_rd", rd, prev_rd);
      @(posedge hclk); #1;
    end
    hready = 1'b1; hresp = 2'b00; hrdata = $urandom;
    check("done_ack", {31'b0, ack}, {31'b0, v.exp_ack});
    check("done_err", {31'b0, err}, {31'b0, v.exp_err});
    check("done_rd", rd, v.exp_rd);
    check("done_htrans", {30'b0, htrans}, 32'd0);
    @(posedge hclk); #1;
    check("post_pulse", {30'b0, ack, err}, 32'd0);
    check("post_busy", {31'b0, busy}, 32'd0);
    check("post_rd", rd, v.exp_rd);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_htrans"}, {30'b0, htrans}, 32'd0);
    check({tag, "_hwrite"}, {31'b0, hwrite}, 32'd0);
    check({tag, "_haddr"}, haddr, 32'd0);
    check({tag, "_hwdata"}, hwdata, 32'd0);
    check({tag, "_hsize"}, {29'b0, hsize}, 32'd0);
    check({tag, "_ack"}, {31'b0, ack}, 32'd0);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_rd"}, rd, 32'd0);
  endtask

  xfer_t       vecs[10];
  logic [31:0] cur_rd;

  initial begin
    xfer_t v;
    int    n0;

    hreset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wd = '0; size = '0;
    hrdata = '0; hready = 1'b1; hresp = 2'b00;

    //                we    addr          wd            sz  aw dw rerr  rdata         legal ack  err  rd
    vecs[0] = mk(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 0, 0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0);
    vecs[1] = mk(1'b0, 32'h204, 32'h0,        2'd2, 0, 3, 1'b0, 32'h12345678, 1'b1, 1'b1, 1'b0, 32'h12345678);
    vecs[2] = mk(1'b1, 32'h300, 32'hCAFEF00D, 2'd2, 0, 0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h12345678);
    vecs[3] = mk(1'b1, 32'h400, 32'h0BADBEEF, 2'd2, 0, 1, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 32'h12345678);
    vecs[4] = mk(1'b0, 32'h3,   32'h0,        2'd1, 0, 0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678);
    vecs[5] = mk(1'b0, 32'h6,   32'h0,        2'd1, 0, 0, 1'b0, 32'h5A5AA5A5, 1'b1, 1'b1, 1'b0, 32'h5A5AA5A5);
    vecs[6] = mk(1'b0, 32'h8,   32'h0,        2'd3, 0, 0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h5A5AA5A5);
    vecs[7] = mk(1'b0, 32'h13,  32'h0,        2'd0, 2, 1, 1'b0, 32'h000000C3, 1'b1, 1'b1, 1'b0, 32'h000000C3);
    vecs[8] = mk(1'b0, 32'h22,  32'h0,        2'd2, 0, 0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h000000C3);
    vecs[9] = mk(1'b0, 32'h40,  32'h0,        2'd2, 0, 0, 1'b1, 32'h77777777, 1'b1, 1'b0, 1'b1, 32'h000000C3);

    // Reset state.
    repeat (2) @(posedge hclk);
    #1;
    check_reset_outputs("reset");
    hreset = 1'b0;
    cur_rd = 32'h0;

    // Table of hand-computed transfers.
    for (int i = 0; i < 10; i++) begin
      run_xfer(vecs[i], cur_rd);
      cur_rd = vecs[i].exp_rd;
    end

    // Randomized transfers against the model.
    for (int n = 0; n < 40; n++) begin
      v.we       = $urandom_range(0, 1);
      v.addr     = $urandom;
      v.wd       = $urandom;
      v.size     = $urandom_range(0, 3);
      v.aw       = $urandom_range(0, 2);
      v.dw       = $urandom_range(0, 3);
      v.resp_err = ($urandom_range(0, 3) == 0);
      v.rdata    = $urandom;
      v = model(v, cur_rd);
      run_xfer(v, cur_rd);
      cur_rd = v.exp_rd;
    end

    // req held through a transfer is not queued.
    n0 = nonseq_cnt;
    req = 1'b1; we = 1'b1; addr = 32'h600; wd = 32'h11112222; size = 2'd2;
    hready = 1'b1; hresp = 2'b00;
    @(posedge hclk); #1;
    addr = 32'h700;
    check("nq_htrans", {30'b0, htrans}, 32'h2);
    check("nq_haddr", haddr, 32'h600);
    @(posedge hclk); #1;
    check("nq_hwdata", hwdata, 32'h11112222);
    @(posedge hclk); #1;
    req = 1'b0;
    check("nq_ack", {31'b0, ack}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge hclk); #1;
      check("nq_idle_busy", {31'b0, busy}, 32'd0);
      check("nq_idle_htrans", {30'b0, htrans}, 32'd0);
    end
    check("nq_one_xfer", nonseq_cnt - n0, 32'd1);

    // Reset in the data phase with req held high.
    n0 = nonseq_cnt;
    req = 1'b1; we = 1'b1; addr = 32'h500; wd = 32'hA5A5A5A5; size = 2'd2;
    hready = 1'b1; hresp = 2'b00;
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    hready = 1'b0;
    check("rst_in_data", {30'b0, htrans}, 32'd0);
    #3;
    hreset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    check("midrst_one_xfer", nonseq_cnt - n0, 32'd1);
    req = 1'b0;
    @(posedge hclk);
    hready = 1'b1; hresp = 2'b01;
    @(posedge hclk); #1;
    hreset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("postrst_quiet", {29'b0, ack, err, busy}, 32'd0);
      @(posedge hclk); #1;
    end
    hresp = 2'b00;

    // First request is taken on the first edge after reset release.
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    run_xfer(mk(1'b0, 32'h80, 32'h0, 2'd2, 0, 0, 1'b0, 32'h87654321,
                1'b1, 1'b1, 1'b0, 32'h87654321), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
